// File: rtl/prim_clk_sel_pkg.sv
// Shared types and constants for the clock-mux select sequencer.
package prim_clk_sel_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SWITCH   = 2'd2,
        DONE     = 2'd3
    } clk_sel_state_e;

    localparam int SwitchCntW = 8;

endpackage

// File: rtl/prim_clk_sel_timer.sv
// Loadable down-counter that stops at zero; shared by the gate-off and settle phases.
module prim_clk_sel_timer #(
    parameter int Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic [Width-1:0] value_o,
    output logic             zero_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign value_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/prim_clock_mux_sel_ctrl.sv
// Select/gate sequencer for a two-input clock mux: close gate, switch select, settle, reopen.
// Optional switch counter enabled by defining PRIM_CLK_SEL_SWITCH_CNT_EN.
module prim_clock_mux_sel_ctrl
    import prim_clk_sel_pkg::*;
#(
    parameter int   GateCycles   = 4,
    parameter int   SettleCycles = 8,
    parameter logic ResetSel     = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  target_i,
    output logic                  ready_o,
    output logic                  sel_o,
    output logic                  gate_en_o,
    output logic                  ack_o,
    output logic                  busy_o,
    output logic [SwitchCntW-1:0] switch_cnt_o
);

    localparam int MaxCycles = (GateCycles > SettleCycles) ? GateCycles : SettleCycles;
    localparam int TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    clk_sel_state_e state_q, state_d;
    logic           target_q, target_d;
    logic           sel_q, sel_d;
    logic           gate_en_q, gate_en_d;
    logic           ack_q, ack_d;

    logic              timer_load;
    logic [TimerW-1:0] timer_load_val;
    logic [TimerW-1:0] timer_value;
    logic              timer_zero;

    prim_clk_sel_timer #(
        .Width(TimerW)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (timer_load),
        .load_val_i(timer_load_val),
        .value_o   (timer_value),
        .zero_o    (timer_zero)
    );

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        sel_d          = sel_q;
        timer_load     = 1'b0;
        timer_load_val = '0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    target_d = target_i;
                    if (target_i != sel_q) begin
                        state_d        = GATE_OFF;
                        timer_load     = 1'b1;
                        timer_load_val = TimerW'(GateCycles - 1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            GATE_OFF: begin
                if (timer_zero) begin
                    state_d        = SWITCH;
                    sel_d          = target_q;
                    timer_load     = 1'b1;
                    timer_load_val = TimerW'(SettleCycles - 1);
                end
            end
            SWITCH: begin
                if (timer_value == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they are registered yet aligned with it.
    assign gate_en_d = (state_d == IDLE) || (state_d == DONE);
    assign ack_d     = (state_d == DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            target_q  <= ResetSel;
            sel_q     <= ResetSel;
            gate_en_q <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            sel_q     <= sel_d;
            gate_en_q <= gate_en_d;
            ack_q     <= ack_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign busy_o    = (state_q != IDLE);
    assign sel_o     = sel_q;
    assign gate_en_o = gate_en_q;
    assign ack_o     = ack_q;

`ifdef PRIM_CLK_SEL_SWITCH_CNT_EN
    logic [SwitchCntW-1:0] switch_cnt_q, switch_cnt_d;

    always_comb begin
        switch_cnt_d = switch_cnt_q;
        if ((sel_d != sel_q) && (switch_cnt_q != '1)) begin
            switch_cnt_d = switch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            switch_cnt_q <= '0;
        end else begin
            switch_cnt_q <= switch_cnt_d;
        end
    end

    assign switch_cnt_o = switch_cnt_q;
`else
    assign switch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_prim_clock_mux_sel_ctrl.sv
// Directed bench for prim_clock_mux_sel_ctrl with default timing (GateCycles=4, SettleCycles=8).
module tb_prim_clock_mux_sel_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       req_i;
    logic       target_i;
    logic       ready_o;
    logic       sel_o;
    logic       gate_en_o;
    logic       ack_o;
    logic       busy_o;
    logic [7:0] switch_cnt_o;

    int         total = 0;
    int         bad   = 0;
    logic       exp_sel;
    logic [7:0] exp_cnt;

    prim_clock_mux_sel_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .target_i    (target_i),
        .ready_o     (ready_o),
        .sel_o       (sel_o),
        .gate_en_o   (gate_en_o),
        .ack_o       (ack_o),
        .busy_o      (busy_o),
        .switch_cnt_o(switch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] cnt_after_switch(input logic [7:0] c);
`ifdef PRIM_CLK_SEL_SWITCH_CNT_EN
        return (c == 8'd255) ? 8'd255 : c + 8'd1;
`else
        return 8'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sel"},   {7'd0, sel_o},     8'd0);
        check({tag, "_gate"},  {7'd0, gate_en_o}, 8'd1);
        check({tag, "_ready"}, {7'd0, ready_o},   8'd1);
        check({tag, "_ack"},   {7'd0, ack_o},     8'd0);
        check({tag, "_busy"},  {7'd0, busy_o},    8'd0);
        check({tag, "_cnt"},   switch_cnt_o,      8'd0);
    endtask

    // Accept at cycle t; sel changes at t+5, ack/gate reopen at t+13, ready at t+14.
    task automatic do_switch(input logic tgt, input bit full);
        logic       old_sel;
        logic [7:0] old_cnt;
        logic [7:0] new_cnt;
        old_sel = exp_sel;
        old_cnt = exp_cnt;
        new_cnt = cnt_after_switch(exp_cnt);
        @(negedge clk_i);
        req_i    = 1'b1;
        target_i = tgt;
        check("sw_accept_ready", {7'd0, ready_o}, 8'd1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk_i);
            if (k == 1) req_i = 1'b0;
            target_i = ~tgt;
            if (full && k <= 12) begin
                check($sformatf("sw_gate_k%0d", k),  {7'd0, gate_en_o}, 8'd0);
                check($sformatf("sw_ready_k%0d", k), {7'd0, ready_o},   8'd0);
                check($sformatf("sw_ack_k%0d", k),   {7'd0, ack_o},     8'd0);
            end
            if (full && k <= 13) begin
                check($sformatf("sw_sel_k%0d", k), {7'd0, sel_o},
                      {7'd0, (k >= 5) ? tgt : old_sel});
                check($sformatf("sw_cnt_k%0d", k), switch_cnt_o,
                      (k >= 5) ? new_cnt : old_cnt);
            end
            if (k == 13) begin
                check("sw_done_ack",  {7'd0, ack_o},     8'd1);
                check("sw_done_gate", {7'd0, gate_en_o}, 8'd1);
            end
            if (k == 14) begin
                check("sw_end_ready", {7'd0, ready_o}, 8'd1);
                check("sw_end_ack",   {7'd0, ack_o},   8'd0);
                check("sw_end_sel",   {7'd0, sel_o},   {7'd0, tgt});
                check("sw_end_cnt",   switch_cnt_o,    new_cnt);
            end
        end
        exp_sel = tgt;
        exp_cnt = new_cnt;
    endtask

    initial begin
        logic tgt;
        rst_i    = 1'b1;
        req_i    = 1'b0;
        target_i = 1'b0;
        exp_sel  = 1'b0;
        exp_cnt  = 8'd0;

        repeat (2) @(negedge clk_i);
        check_reset_values("in_reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_values("idle");

        // Same-target request: ack next cycle, gate never drops.
        req_i    = 1'b1;
        target_i = exp_sel;
        @(negedge clk_i);
        req_i = 1'b0;
        check("same_ack",   {7'd0, ack_o},     8'd1);
        check("same_gate",  {7'd0, gate_en_o}, 8'd1);
        check("same_sel",   {7'd0, sel_o},     {7'd0, exp_sel});
        check("same_ready", {7'd0, ready_o},   8'd0);
        check("same_busy",  {7'd0, busy_o},    8'd1);
        @(negedge clk_i);
        check("same_ack_end",   {7'd0, ack_o},     8'd0);
        check("same_ready_end", {7'd0, ready_o},   8'd1);
        check("same_gate_end",  {7'd0, gate_en_o}, 8'd1);
        check("same_cnt",       switch_cnt_o,      exp_cnt);

        do_switch(1'b1, 1'b1);
        do_switch(1'b0, 1'b1);

        // req_i held high, target toggled at each accept and scrambled while busy.
        @(negedge clk_i);
        req_i    = 1'b1;
        target_i = ~exp_sel;
        check("hold_ready0", {7'd0, ready_o}, 8'd1);
        for (int n = 0; n < 3; n++) begin
            tgt = target_i;
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk_i);
                if (k < 14) target_i = 1'($urandom);
                if (k == 1)  check($sformatf("hold_busy_n%0d", n), {7'd0, ready_o}, 8'd0);
                if (k == 13) check($sformatf("hold_ack_n%0d", n),  {7'd0, ack_o},   8'd1);
                if (k == 14) begin
                    exp_sel = tgt;
                    exp_cnt = cnt_after_switch(exp_cnt);
                    check($sformatf("hold_ready_n%0d", n), {7'd0, ready_o}, 8'd1);
                    check($sformatf("hold_sel_n%0d", n),   {7'd0, sel_o},   {7'd0, exp_sel});
                    check($sformatf("hold_cnt_n%0d", n),   switch_cnt_o,    exp_cnt);
                    if (n < 2) target_i = ~tgt;
                    else req_i = 1'b0;
                end
            end
        end

        if (exp_sel != 1'b0) do_switch(1'b0, 1'b0);

        // Asynchronous reset at t+7 of a 0->1 switch.
        @(negedge clk_i);
        req_i    = 1'b1;
        target_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_i);
            req_i = 1'b0;
        end
        check("pre_rst_sel",  {7'd0, sel_o},     8'd1);
        check("pre_rst_gate", {7'd0, gate_en_o}, 8'd0);
        rst_i = 1'b1;
        #1;
        exp_sel = 1'b0;
        exp_cnt = 8'd0;
        check_reset_values("async_rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check($sformatf("rst_no_ack_%0d", k), {7'd0, ack_o}, 8'd0);
        end
        rst_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_i);
            check($sformatf("post_rst_no_ack_%0d", k), {7'd0, ack_o}, 8'd0);
        end
        check_reset_values("post_rst");

        // 300 alternating switches: counter saturates at 255 when built.
        for (int i = 0; i < 300; i++) begin
            do_switch(~exp_sel, 1'b0);
        end
`ifdef PRIM_CLK_SEL_SWITCH_CNT_EN
        check("sat_cnt", switch_cnt_o, 8'd255);
`else
        check("sat_cnt", switch_cnt_o, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prim_clock_mux_sel_ctrl.md
# prim_clock_mux_sel_ctrl

Sequencer that drives the select and output clock-gate enable of the generic two-input clock mux. It accepts a switch request on a valid/ready handshake and closes the downstream clock gate. It then holds the gate closed while the mux select changes and settles, reopens the gate, and signals completion. It runs on a single always-on clock and feeds the mux select and the clock gate that follows the mux.

## Interface
- GateCycles, 4: cycles the gate is held closed before the select changes; must be >= 1
- SettleCycles, 8: cycles the gate is held closed after the select changes; must be >= 1
- ResetSel, 1'b0: value of sel_o during and after reset
- clk_i  input  1  always-on clock
- rst_i  input  1  reset, asynchronous and active-high
- req_i  input  1  switch request valid
- target_i  input  1  requested select value
- ready_o  output  1  request accepted when req_i && ready_o
- sel_o  output  1  mux select (connects to the mux sel_i)
- gate_en_o  output  1  downstream clock-gate enable
- ack_o  output  1  one-cycle completion pulse
- busy_o  output  1  high in any state other than IDLE
- switch_cnt_o  output  8  number of completed select changes (see Configuration)

## Operation
- States (prim_clk_sel_pkg::clk_sel_state_e): IDLE, GATE_OFF, SWITCH, DONE.
- IDLE
  - ready_o=1, gate_en_o=1.
  - On accept with target_i != sel_o: go to GATE_OFF and load the timer with GateCycles-1.
  - On accept with target_i == sel_o: go to DONE directly. No gating, sel_o unchanged, counter unchanged.
- GATE_OFF
  - gate_en_o=0.
  - When the timer reaches 0: go to SWITCH, set sel_o to the latched target, and load the timer with SettleCycles-1.
- SWITCH
  - gate_en_o=0, sel_o holds the new value.
  - When the timer reaches 0: go to DONE.
- DONE
  - gate_en_o=1, ack_o=1 for exactly this one cycle.
  - Go to IDLE next cycle.
- Request handling
  - target_i is latched at accept; changes on target_i after accept are ignored.
  - ready_o=0 in every state other than IDLE.
  - req_i while not ready is not queued; the requester must hold it.
- Timer: down-counter of width $clog2(max(GateCycles,SettleCycles)). A count of 0 means the current state ends this cycle.
- Reset
  - Values during reset: state=IDLE, sel_o=ResetSel, gate_en_o=1, ready_o=1, ack_o=0, busy_o=0, switch_cnt_o=0.
  - Reset asserted mid-sequence aborts immediately to these values; no ack is produced.
- sel_o, gate_en_o and ack_o are registered outputs with no combinational path from the inputs. ready_o and busy_o decode the state.

## Timing
- Accept at cycle t.
- Switching request (target != sel_o):
  - gate_en_o=0 from t+1.
  - sel_o changes at t+GateCycles+1.
  - gate_en_o=1 and ack_o=1 at t+GateCycles+SettleCycles+1.
  - ready_o=1 at t+GateCycles+SettleCycles+2.
- Same-target request: ack_o at t+1, ready_o at t+2; gate_en_o stays 1 throughout.
- Back-to-back requests: the earliest next accept is the first cycle ready_o=1. No request is accepted in the DONE cycle.

## Configuration
- Macro: PRIM_CLK_SEL_SWITCH_CNT_EN.
- Defined:
  - switch_cnt_o increments in the cycle sel_o changes.
  - It saturates at 255.
  - It is cleared only by reset.
- Undefined: switch_cnt_o is tied to 8'h00 and no counter flops are built. The port is always present.

## Structure
- prim_clk_sel_pkg holds:
  - clk_sel_state_e, a 2-bit enum;
  - the counter width constant SwitchCntW = 8.
- One sub-module, prim_clk_sel_timer: a loadable down-counter with load, value and zero-flag outputs. It is instantiated once and shared by GATE_OFF and SWITCH.
- The FSM, target latch and switch counter live in the top module.

## Test plan
- Reset, then idle: sel_o=0, gate_en_o=1, ready_o=1, ack_o=0, switch_cnt_o=0.
- Accept target=1 at t with defaults:
  - gate_en_o=0 over t+1..t+12;
  - sel_o=1 at t+5;
  - gate_en_o=1 and ack_o=1 at t+13;
  - ready_o=1 at t+14;
  - switch_cnt_o=1.
- Accept target=0 while sel_o=0: ack_o at t+1, gate_en_o never drops, switch_cnt_o unchanged.
- Hold req_i high continuously, toggling target_i at every accept:
  - one accept per 14 cycles;
  - target_i changes during the busy period have no effect.
- Assert rst_i at t+7 of a switch:
  - outputs return to their reset values asynchronously;
  - no ack_o;
  - sel_o=ResetSel.
- With PRIM_CLK_SEL_SWITCH_CNT_EN defined, run 300 alternating switches: switch_cnt_o saturates at 255. Without the macro, switch_cnt_o reads 0 throughout.
